// File: rtl/axi_sub_rd_eng_pkg.sv
// Shared AXI encodings and local types for the AXI read-channel subordinate engine.
package axi_sub_rd_eng_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    // Only these lengths form a legal wrapping burst; anything else behaves as INCR.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        logic ok;
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/axi_sub_rd_eng_chk.sv
// Protocol checker for the read engine: buffer overflow and handshake-stability properties.
module axi_sub_rd_eng_chk #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int UW = 32,
    parameter int IW = 1,
    parameter int BW = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic          full,
    input logic          r_dv,
    input logic          r_hld,
    input logic [AW-1:0] r_addr,
    input logic [UW-1:0] r_user,
    input logic [IW-1:0] r_id,
    input logic [2:0]    r_size,
    input logic          r_last,
    input logic          rvalid,
    input logic          rready,
    input logic [DW-1:0] rdata,
    input logic [1:0]    rresp,
    input logic [IW-1:0] rid,
    input logic          rlast
);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full));

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (r_dv && r_hld) |=> (r_dv && $stable(r_addr) && $stable(r_user) && $stable(r_id)
                             && $stable(r_size) && $stable(r_last)));

    a_r_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rvalid && !rready) |=> (rvalid && $stable(rdata) && $stable(rresp)
                                 && $stable(rid) && $stable(rlast)));

    c_oversize_beat: cover property (@(posedge clk) disable iff (!rst_n)
        r_dv && !r_hld && (r_size > 3'(BW)));

endmodule

// File: rtl/axi_sub_rd_fifo.sv
// Synchronous FIFO with occupancy count; holds returned read beats until the R channel takes them.
module axi_sub_rd_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(DEPTH - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1'b1);
        end
        return n;
    endfunction

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Entry storage and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
        end
    end

    // Read pointer and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/axi_sub_rd_eng.sv
// AXI4 read subordinate engine: expands one AR burst into per-beat component requests and
// returns the component's data on the R channel through a credit-protected buffer.
module axi_sub_rd_eng
    import axi_sub_rd_eng_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int BC    = DW / 8,
    parameter int BW    = $clog2(BC),
    parameter int UW    = 32,
    parameter int IW    = 1,
    parameter int C_LAT = 0,
    parameter int DEPTH = C_LAT + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_axi_arvalid,
    output logic          s_axi_arready,
    input  logic [AW-1:0] s_axi_araddr,
    input  logic [1:0]    s_axi_arburst,
    input  logic [2:0]    s_axi_arsize,
    input  logic [7:0]    s_axi_arlen,
    input  logic [UW-1:0] s_axi_aruser,
    input  logic [IW-1:0] s_axi_arid,
    output logic          s_axi_rvalid,
    input  logic          s_axi_rready,
    output logic [DW-1:0] s_axi_rdata,
    output logic [1:0]    s_axi_rresp,
    output logic [IW-1:0] s_axi_rid,
    output logic          s_axi_rlast,
    output logic          r_dv,
    output logic [AW-1:0] r_addr,
    output logic [UW-1:0] r_user,
    output logic [IW-1:0] r_id,
    output logic [2:0]    r_size,
    output logic          r_last,
    input  logic          r_hld,
    input  logic          r_err,
    input  logic [DW-1:0] r_rdata
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            EW      = DW + 1 + IW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    rd_state_e     state_r, state_nxt_s;
    logic [AW-1:0] addr_r, addr_nxt_s;
    logic [1:0]    burst_r;
    logic [2:0]    size_r;
    logic [7:0]    len_r, beat_r;
    logic [UW-1:0] user_r;
    logic [IW-1:0] id_r;
    logic [AW-1:0] step_s, wrap_bnd_s, incr_nxt_s, wrap_sum_s;
    logic          ar_hs_s, beat_acc_s, last_beat_s, credit_ok_s;
    logic          arready_s, dv_s;
    logic [CW-1:0] fifo_cnt_s, inflight_s;
    logic          push_s, push_last_s, pop_s, fifo_full_s, fifo_empty_s;
    logic [IW-1:0] push_id_s;
    logic [EW-1:0] fifo_wdata_s, fifo_rdata_s;

    assign ar_hs_s     = s_axi_arvalid && arready_s;
    assign beat_acc_s  = dv_s && !r_hld;
    assign last_beat_s = (beat_r == len_r);
    // Beats already buffered plus beats still inside the component must fit in the buffer.
    assign credit_ok_s = ({1'b0, fifo_cnt_s} + {1'b0, inflight_s}) < DEPTH_C;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (ar_hs_s) begin
                    state_nxt_s = BURST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BURST: begin
                if (beat_acc_s && last_beat_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BURST;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: AR acceptance only when idle, beat requests only while credits remain.
    always_comb begin
        arready_s = 1'b0;
        dv_s      = 1'b0;
        case (state_r)
            IDLE:    arready_s = 1'b1;
            BURST:   dv_s      = credit_ok_s;
            default: arready_s = 1'b0;
        endcase
    end

    // Next beat address for FIXED / INCR / WRAP, all in AW-bit modular arithmetic.
    always_comb begin
        step_s     = AW'(1'b1) << size_r;
        wrap_bnd_s = AW'({1'b0, len_r} + 9'd1) << size_r;
        incr_nxt_s = (addr_r & ~(step_s - AW'(1'b1))) + step_s;
        wrap_sum_s = addr_r + step_s;
        addr_nxt_s = incr_nxt_s;
        case (burst_r)
            AXI_BURST_FIXED: addr_nxt_s = addr_r;
            AXI_BURST_INCR:  addr_nxt_s = incr_nxt_s;
            AXI_BURST_WRAP: begin
                if (!wrap_len_ok(len_r)) begin
                    addr_nxt_s = incr_nxt_s;
                end else if ((wrap_sum_s & (wrap_bnd_s - AW'(1'b1))) == {AW{1'b0}}) begin
                    addr_nxt_s = wrap_sum_s - wrap_bnd_s;
                end else begin
                    addr_nxt_s = wrap_sum_s;
                end
            end
            default: addr_nxt_s = incr_nxt_s;
        endcase
    end

    // Burst context capture and per-beat address / counter advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r  <= {AW{1'b0}};
            burst_r <= 2'd0;
            size_r  <= 3'd0;
            len_r   <= 8'd0;
            beat_r  <= 8'd0;
            user_r  <= {UW{1'b0}};
            id_r    <= {IW{1'b0}};
        end else if (ar_hs_s) begin
            addr_r  <= s_axi_araddr;
            burst_r <= s_axi_arburst;
            size_r  <= s_axi_arsize;
            len_r   <= s_axi_arlen;
            beat_r  <= 8'd0;
            user_r  <= s_axi_aruser;
            id_r    <= s_axi_arid;
        end else if (beat_acc_s) begin
            addr_r <= addr_nxt_s;
            if (beat_r != 8'hFF) begin
                beat_r <= beat_r + 8'd1;
            end
        end
    end

    assign r_dv   = dv_s;
    assign r_addr = addr_r;
    assign r_user = user_r;
    assign r_id   = id_r;
    assign r_size = size_r;
    assign r_last = last_beat_s;
    assign s_axi_arready = arready_s;

    generate
        if (C_LAT == 0) begin : g_no_pipe
            assign push_s      = beat_acc_s;
            assign push_id_s   = id_r;
            assign push_last_s = last_beat_s;
            assign inflight_s  = {CW{1'b0}};
        end else begin : g_pipe
            logic [C_LAT-1:0] pv_r;
            logic [C_LAT-1:0] plast_r;
            logic [IW-1:0]    pid_r [C_LAT];
            logic [CW-1:0]    inflight_c;

            // Shift pipe tagging each accepted beat until its data returns.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv_r    <= {C_LAT{1'b0}};
                    plast_r <= {C_LAT{1'b0}};
                    for (int i = 0; i < C_LAT; i++) begin
                        pid_r[i] <= {IW{1'b0}};
                    end
                end else begin
                    pv_r[0]    <= beat_acc_s;
                    plast_r[0] <= last_beat_s;
                    pid_r[0]   <= id_r;
                    for (int i = 1; i < C_LAT; i++) begin
                        pv_r[i]    <= pv_r[i-1];
                        plast_r[i] <= plast_r[i-1];
                        pid_r[i]   <= pid_r[i-1];
                    end
                end
            end

            // Count beats still travelling through the component.
            always_comb begin
                inflight_c = {CW{1'b0}};
                for (int i = 0; i < C_LAT; i++) begin
                    inflight_c = inflight_c + CW'(pv_r[i]);
                end
            end

            assign inflight_s  = inflight_c;
            assign push_s      = pv_r[C_LAT-1];
            assign push_id_s   = pid_r[C_LAT-1];
            assign push_last_s = plast_r[C_LAT-1];
        end
    endgenerate

    assign fifo_wdata_s = {r_rdata, r_err, push_id_s, push_last_s};
    assign pop_s        = !fifo_empty_s && s_axi_rready;

    axi_sub_rd_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (fifo_wdata_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_cnt_s)
    );

    assign s_axi_rvalid = !fifo_empty_s;
    assign s_axi_rdata  = fifo_rdata_s[EW-1 -: DW];
    assign s_axi_rresp  = fifo_rdata_s[IW+1] ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign s_axi_rid    = fifo_rdata_s[IW:1];
    assign s_axi_rlast  = fifo_rdata_s[0];

    axi_sub_rd_eng_chk #(
        .AW (AW),
        .DW (DW),
        .UW (UW),
        .IW (IW),
        .BW (BW)
    ) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push_s),
        .full   (fifo_full_s),
        .r_dv   (dv_s),
        .r_hld  (r_hld),
        .r_addr (addr_r),
        .r_user (user_r),
        .r_id   (id_r),
        .r_size (size_r),
        .r_last (last_beat_s),
        .rvalid (s_axi_rvalid),
        .rready (s_axi_rready),
        .rdata  (s_axi_rdata),
        .rresp  (s_axi_rresp),
        .rid    (s_axi_rid),
        .rlast  (s_axi_rlast)
    );

endmodule

// File: tb/tb_axi_sub_rd_eng.sv
// Scoreboard bench for axi_sub_rd_eng: a reference burst expander feeds expected beats,
// a component model returns random data C_LAT cycles later, and a monitor checks both sides.
module tb_axi_sub_rd_eng;
    import axi_sub_rd_eng_pkg::*;

    localparam int AW = 32, DW = 32, UW = 32, IW = 1;
    localparam int C_LAT = 2;
    localparam int DEPTH = C_LAT + 2;

    logic clk, rst_n;
    logic s_axi_arvalid, s_axi_arready;
    logic [AW-1:0] s_axi_araddr;
    logic [1:0] s_axi_arburst;
    logic [2:0] s_axi_arsize;
    logic [7:0] s_axi_arlen;
    logic [UW-1:0] s_axi_aruser;
    logic [IW-1:0] s_axi_arid;
    logic s_axi_rvalid, s_axi_rready;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0] s_axi_rresp;
    logic [IW-1:0] s_axi_rid;
    logic s_axi_rlast;
    logic r_dv, r_last, r_hld, r_err;
    logic [AW-1:0] r_addr;
    logic [UW-1:0] r_user;
    logic [IW-1:0] r_id;
    logic [2:0] r_size;
    logic [DW-1:0] r_rdata;

    axi_sub_rd_eng #(.AW(AW), .DW(DW), .UW(UW), .IW(IW), .C_LAT(C_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst),
        .s_axi_arsize(s_axi_arsize), .s_axi_arlen(s_axi_arlen),
        .s_axi_aruser(s_axi_aruser), .s_axi_arid(s_axi_arid),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rid(s_axi_rid), .s_axi_rlast(s_axi_rlast),
        .r_dv(r_dv), .r_addr(r_addr), .r_user(r_user), .r_id(r_id),
        .r_size(r_size), .r_last(r_last), .r_hld(r_hld), .r_err(r_err),
        .r_rdata(r_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [UW-1:0] user;
        logic [IW-1:0] id;
        logic [2:0]    size;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic [IW-1:0] id;
        logic          last;
    } rbeat_t;

    beat_t  exp_beats[$];
    rbeat_t exp_r[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int err_at = -1;
    bit rand_mode = 1'b0;
    bit rand_err = 1'b0;
    logic [DW-1:0] sched_data [16];
    logic          sched_err  [16];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference burst expansion: list every beat address straight from the burst rules.
    task automatic expand(input logic [AW-1:0] addr, input logic [1:0] burst, input logic [2:0] size,
                          input logic [7:0] len, input logic [UW-1:0] user, input logic [IW-1:0] id);
        longint unsigned a, step, total, mask;
        beat_t b;
        bit is_wrap;
        mask  = 64'hFFFF_FFFF;
        a     = addr;
        step  = 64'd1 << size;
        total = (longint'(len) + 1) * step;
        is_wrap = (burst == AXI_BURST_WRAP) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        for (int i = 0; i <= int'(len); i++) begin
            b.addr = a[AW-1:0]; b.user = user; b.id = id; b.size = size; b.last = (i == int'(len));
            exp_beats.push_back(b);
            if (burst == AXI_BURST_FIXED) begin
                a = a;
            end else if (is_wrap) begin
                a = (a + step) & mask;
                if (a % total == 0) a = (a + (mask + 1) - total) & mask;
            end else begin
                a = (((a / step) * step) + step) & mask;
            end
        end
    endtask

    // Component model: returns data C_LAT cycles after each accepted beat.
    always @(posedge clk) begin
        cyc++;
        #1;
        r_rdata = sched_data[cyc % 16];
        r_err   = sched_err[cyc % 16];
    end

    // Background random handshake pressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                s_axi_rready = ($urandom_range(0, 3) != 0);
                r_hld        = ($urandom_range(0, 3) == 0);
            end
        end
    end

    bit held_prev = 1'b0;
    logic [AW-1:0] addr_prev;
    bit rstall_prev = 1'b0;
    logic [DW-1:0] rdata_prev;

    // Monitor: checks issued beats and R beats against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (held_prev) begin
                chk("hold_dv", r_dv, 1);
                chk("hold_addr", r_addr, addr_prev);
            end
            if (rstall_prev) begin
                chk("rstall_valid", s_axi_rvalid, 1);
                chk("rstall_data", s_axi_rdata, rdata_prev);
            end
            held_prev   = r_dv && r_hld;
            addr_prev   = r_addr;
            rstall_prev = s_axi_rvalid && !s_axi_rready;
            rdata_prev  = s_axi_rdata;
            if (r_dv && !r_hld) begin
                if (exp_beats.size() == 0) begin
                    chk("unexpected_beat", r_addr, 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    beat_t e;
                    rbeat_t rb;
                    e = exp_beats.pop_front();
                    chk("r_addr", r_addr, e.addr);
                    chk("r_last", r_last, e.last);
                    chk("r_user", r_user, e.user);
                    chk("r_id", r_id, e.id);
                    chk("r_size", r_size, e.size);
                    rb.data = $urandom;
                    rb.err  = (acc_cnt == err_at) || (rand_err && ($urandom_range(0, 7) == 0));
                    rb.id   = e.id;
                    rb.last = e.last;
                    sched_data[(cyc + C_LAT) % 16] = rb.data;
                    sched_err[(cyc + C_LAT) % 16]  = rb.err;
                    exp_r.push_back(rb);
                end
                acc_cnt++;
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) begin
                    chk("unexpected_r", s_axi_rdata, 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    rbeat_t x;
                    x = exp_r.pop_front();
                    chk("rdata", s_axi_rdata, x.data);
                    chk("rresp", s_axi_rresp, x.err ? 64'd2 : 64'd0);
                    chk("rid", s_axi_rid, x.id);
                    chk("rlast", s_axi_rlast, x.last);
                end
            end
        end else begin
            held_prev   = 1'b0;
            rstall_prev = 1'b0;
        end
    end

    task automatic send_ar(input logic [AW-1:0] a, input logic [1:0] b, input logic [2:0] s,
                           input logic [7:0] l);
        int n;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b1; s_axi_araddr = a; s_axi_arburst = b; s_axi_arsize = s;
        s_axi_arlen = l; s_axi_aruser = $urandom; s_axi_arid = IW'($urandom_range(0, 1));
        n = 0;
        forever begin
            @(negedge clk);
            if (s_axi_arready) break;
            n++;
            if (n > 2000) break;
        end
        if (n > 2000) begin
            chk("arready_timeout", 0, 1);
        end else begin
            expand(a, b, s, l, s_axi_aruser, s_axi_arid);
        end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_r.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) chk("drain_timeout", exp_beats.size() + exp_r.size(), 0);
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("accept_timeout", acc_cnt, target);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arburst = 2'd0;
        s_axi_arsize = 3'd0; s_axi_arlen = 8'd0; s_axi_aruser = '0; s_axi_arid = '0;
        s_axi_rready = 1'b1; r_hld = 1'b0; r_err = 1'b0; r_rdata = '0;
        for (int i = 0; i < 16; i++) begin sched_data[i] = '0; sched_err[i] = 1'b0; end
        repeat (3) @(negedge clk);
        chk("rst_arready", s_axi_arready, 1);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_dv", r_dv, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", s_axi_arready, 1);
        chk("post_rst_rvalid", s_axi_rvalid, 0);

        // Address patterns: INCR, WRAP, FIXED, unaligned INCR.
        send_ar(32'h100, AXI_BURST_INCR, 3'd2, 8'd3);  wait_drain();
        send_ar(32'h1C, AXI_BURST_WRAP, 3'd2, 8'd3);   wait_drain();
        send_ar(32'h40, AXI_BURST_FIXED, 3'd2, 8'd2);  wait_drain();
        send_ar(32'h41, AXI_BURST_INCR, 3'd2, 8'd2);   wait_drain();

        // Back-pressure: issue must stall after exactly DEPTH beats.
        s_axi_rready = 1'b0;
        base = acc_cnt;
        send_ar(32'h200, AXI_BURST_INCR, 3'd2, 8'd7);
        repeat (20) @(negedge clk);
        chk("stall_beats", acc_cnt - base, DEPTH);
        chk("stall_dv", r_dv, 0);
        @(posedge clk); #1; s_axi_rready = 1'b1;
        wait_drain();

        // Arbiter hold mid-burst, error on the second beat only.
        base = acc_cnt;
        err_at = base + 1;
        send_ar(32'h300, AXI_BURST_INCR, 3'd2, 8'd7);
        wait_acc(base + 3);
        @(posedge clk); #1; r_hld = 1'b1;
        base = acc_cnt;
        repeat (5) @(negedge clk);
        chk("hold_no_beats", acc_cnt - base, 0);
        chk("hold_dv_high", r_dv, 1);
        @(posedge clk); #1; r_hld = 1'b0;
        wait_drain();
        err_at = -1;

        // Reset mid-burst with beats in flight and buffered.
        s_axi_rready = 1'b0;
        base = acc_cnt;
        send_ar(32'h400, AXI_BURST_INCR, 3'd2, 8'd7);
        wait_acc(base + 3);
        @(posedge clk); #1; rst_n = 1'b0;
        exp_beats.delete(); exp_r.delete();
        @(negedge clk);
        chk("midrst_rvalid", s_axi_rvalid, 0);
        chk("midrst_dv", r_dv, 0);
        chk("midrst_arready", s_axi_arready, 1);
        @(posedge clk); #1; rst_n = 1'b1; s_axi_rready = 1'b1;
        @(negedge clk);
        chk("relrst_rvalid", s_axi_rvalid, 0);
        chk("relrst_arready", s_axi_arready, 1);
        send_ar(32'h500, AXI_BURST_WRAP, 3'd3, 8'd7);  wait_drain();

        // Long INCR burst exercising the full 8-bit beat counter.
        send_ar(32'hFFFF_FF00, AXI_BURST_INCR, 3'd0, 8'd255); wait_drain();

        // Randomized bursts under random rready / r_hld / r_err.
        rand_mode = 1'b1; rand_err = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [1:0] b;
            logic [2:0] s;
            logic [7:0] l;
            logic [AW-1:0] a;
            b = 2'($urandom_range(0, 2));
            s = 3'($urandom_range(0, 3));
            l = 8'($urandom_range(0, 15));
            a = $urandom;
            if (b == AXI_BURST_WRAP) a = a & ~((32'd1 << s) - 32'd1);
            send_ar(a, b, s, l);
            wait_drain();
        end
        rand_mode = 1'b0; rand_err = 1'b0;
        @(posedge clk); #1; s_axi_rready = 1'b1; r_hld = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);
        chk("final_rvalid", s_axi_rvalid, 0);
        chk("final_arready", s_axi_arready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_sub_rd_eng.md
Name: axi_sub_rd_eng

Overview:
- AXI4 read-channel subordinate engine; sits directly upstream of the read side of the subordinate arbiter.
- Accepts one AR burst at a time and expands it into per-beat component requests: r_dv, r_addr, r_user, r_id, r_size, r_last.
- Captures r_rdata / r_err returned C_LAT cycles after each accepted beat into a credit-protected buffer, and drives the AXI R channel from it.

Parameters:
AW, 32, address width
DW, 32, data width
BC, DW/8, byte count (derived)
BW, $clog2(BC), byte-count width (derived)
UW, 32, user width
IW, 1, ID width
C_LAT, 0, component latency from accepted beat (r_dv && !r_hld) to r_rdata/r_err; constant
DEPTH, C_LAT+2, response buffer entries (derived; never less than C_LAT+1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_araddr  in  AW  AR byte address
s_axi_arburst  in  2  FIXED=0, INCR=1, WRAP=2
s_axi_arsize  in  3  log2 bytes per beat
s_axi_arlen  in  8  beats minus one
s_axi_aruser  in  UW  AR user
s_axi_arid  in  IW  AR ID
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
s_axi_rdata  out  DW  R data
s_axi_rresp  out  2  OKAY=2'b00, SLVERR=2'b10
s_axi_rid  out  IW  R ID
s_axi_rlast  out  1  R last
r_dv  out  1  beat request
r_addr  out  AW  beat byte address
r_user  out  UW  burst user
r_id  out  IW  burst ID
r_size  out  3  burst size
r_last  out  1  final beat of burst
r_hld  in  1  arbiter hold; beat accepted when r_dv && !r_hld
r_err  in  1  read error, valid with r_rdata
r_rdata  in  DW  read data

Behaviour:
Reset values:
- State IDLE, so s_axi_arready=1 after reset release.
- r_dv=0, s_axi_rvalid=0, buffer empty, in-flight count 0.
- All datapath registers 0.

State machine: IDLE -> BURST on arvalid && arready.
- Capture addr, burst, size, len, user, id; set beat counter to 0.
- arready=1 only in IDLE, so at most one burst is in the issue stage.

BURST, issue rule:
- r_dv=1 iff (buffer occupancy + in-flight beats) < DEPTH.
- r_dv must not drop while r_hld=1 unless credits shrink; credits never shrink while r_dv is held, so r_dv is stable.
- r_addr, r_last and the other request fields must stay stable while r_dv && r_hld.

BURST, on accept:
- Increment the beat counter.
- r_last = (counter == len).
- Accepting the last beat returns to IDLE next cycle; arready=1 that cycle.

Address update (AW-bit arithmetic, wrap modulo 2^AW):
- FIXED: address unchanged.
- INCR: next = (addr aligned down to 1<<size) + (1<<size).
- WRAP: boundary = (len+1) << size. Next = addr + (1<<size); if next reaches a boundary multiple, subtract boundary.
- WRAP with len not in {1,3,7,15} is handled as INCR.
- No 4KB-crossing checks; no range checks.
- arsize > BW: passed through unchanged; the component flags it via r_err.

Return path:
- Each accepted beat enters a C_LAT-stage shift pipe carrying {id, last}.
- At pipe exit, push {r_rdata, r_err, id, last} into the buffer.
- C_LAT=0: push in the same cycle as accept.
- The in-flight count equals the number of valid pipe stages.

R channel:
- rvalid = buffer not empty.
- rresp = stored err ? SLVERR : OKAY.
- Pop on rvalid && rready.
- Simultaneous push and pop keeps occupancy unchanged.
- R output fields must be stable while rvalid && !rready.

Boundaries:
- Buffer full with rready=0: r_dv deasserts; no beat is ever dropped.
- rready=0 indefinitely: issue stalls after DEPTH beats.
- len=255 INCR: the counter is 8-bit and stops at 255.
- rst_n asserted mid-burst: the burst is abandoned, the buffer is flushed, and all outputs return to reset values asynchronously.

Assertions:
- Never push to a full buffer.
- r_dv && r_hld stability.
- rvalid && !rready stability.

Decomposition:
- Shared: burst/resp encodings (AXI_BURST_*, AXI_RESP_*) from axi_pkg.
- Local: state enum typedef {IDLE, BURST}.
- One sub-module, axi_sub_rd_fifo: parameterized synchronous FIFO with WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Async active-low reset.

Test Plan:
1. C_LAT=0, INCR, araddr=0x100, len=3, size=2, rready=1 -> r_addr 0x100,0x104,0x108,0x10C; r_last on beat 4; 4 R beats OKAY; rlast on the 4th.
2. WRAP, araddr=0x1C, len=3, size=2 -> r_addr 0x1C,0x10,0x14,0x18.
3. FIXED, araddr=0x40, len=2 -> r_addr 0x40 x3. Separately, INCR unaligned 0x41 size=2 -> 0x41,0x44,0x48.
4. C_LAT=2, rready=0, len=7 -> exactly DEPTH=4 beats accepted, r_dv then low. rready=1 -> remaining beats resume; 8 R beats in order with matching data.
5. r_hld=1 for 5 cycles mid-burst -> r_dv/r_addr stable; no extra beats. r_err=1 on beat 2 -> rresp=2'b10 on beat 2 only.
6. Assert rst_n low with 2 beats in flight and 1 buffered -> rvalid=0, r_dv=0, arready=1 after release; the next burst completes normally.
